// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: owns head position, 20-slot body history and score, and steps
// IDLE -> RUN -> MOVE -> CHECK -> RUN/OVER around the registered collision checker.
module snake_game_ctrl #(
  parameter int STEP       = 10,
  parameter int X0         = 320,
  parameter int Y0         = 240,
  parameter int CHECK_WAIT = 2,
  parameter int MAX_SCORE  = 18
) (
  input  logic         vga_clk,
  input  logic         rst,
  input  logic         start,
  input  logic         move_tick,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         game_over,
  input  logic         food_hit,
  output logic [9:0]   snakex,
  output logic [9:0]   snakey,
  output logic [199:0] storex,
  output logic [199:0] storey,
  output logic [7:0]   score,
  output logic         playing,
  output logic         over,
  output logic         check_stb,
  output logic [2:0]   state_dbg
);

  localparam int CNT_W = $clog2(CHECK_WAIT + 2);

  // state_dbg encoding: IDLE=0, RUN=1, MOVE=2, CHECK=3, OVER=4
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_MOVE, S_CHECK, S_OVER} state_e;
  // Encoded so that opposite directions differ only in bit 0.
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_e;

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d, req;
  logic               req_valid;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic [199:0]       sx_q, sx_d, sy_q, sy_d;
  logic [7:0]         score_q, score_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= D_RIGHT;
      x_q     <= 10'(X0);
      y_q     <= 10'(Y0);
      sx_q    <= '1;
      sy_q    <= '1;
      score_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    x_d       = x_q;
    y_d       = y_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    score_d   = score_q;
    cnt_d     = cnt_q;
    req       = D_RIGHT;
    req_valid = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_RUN;
          dir_d   = D_RIGHT;
          x_d     = 10'(X0);
          y_d     = 10'(Y0);
          sx_d    = '1;
          sy_d    = '1;
          score_d = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (move_tick) state_d = S_MOVE;
      end
      S_MOVE: begin
        sx_d = {sx_q[189:0], x_q};
        sy_d = {sy_q[189:0], y_q};
        // 10-bit arithmetic wraps modulo 1024; off-field heads are the checker's problem.
        case (dir_q)
          D_UP:    y_d = y_q - 10'(STEP);
          D_DOWN:  y_d = y_q + 10'(STEP);
          D_LEFT:  x_d = x_q - 10'(STEP);
          default: x_d = x_q + 10'(STEP);
        endcase
        cnt_d   = '0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CHECK_WAIT)) begin
          cnt_d = '0;
          if (game_over) begin
            state_d = S_OVER;
          end else begin
            if (food_hit && (score_q < 8'(MAX_SCORE))) score_d = score_q + 8'd1;
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Direction requests are latched during play; a reversal of the current heading is ignored.
    if (state_q == S_RUN || state_q == S_MOVE || state_q == S_CHECK) begin
      req_valid = 1'b1;
      if (btn_up)         req = D_UP;
      else if (btn_down)  req = D_DOWN;
      else if (btn_left)  req = D_LEFT;
      else if (btn_right) req = D_RIGHT;
      else                req_valid = 1'b0;
      if (req_valid && ((req ^ dir_q) != 2'b01)) dir_d = req;
    end
  end

  assign snakex    = x_q;
  assign snakey    = y_q;
  assign storex    = sx_q;
  assign storey    = sy_q;
  assign score     = score_q;
  assign playing   = (state_q == S_RUN) || (state_q == S_MOVE) || (state_q == S_CHECK);
  assign over      = (state_q == S_OVER);
  assign check_stb = (state_q == S_CHECK) && (cnt_q == CNT_W'(CHECK_WAIT));
  assign state_dbg = state_q;

endmodule
